// File: rtl/mem_arb_pkg.sv
// Shared definitions for the single-port memory arbiter: requester IDs,
// FSM state encoding and requester count.
package mem_arb_pkg;

    localparam int NUM_REQ = 3;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_I = 2'd0;
    localparam req_id_t REQ_D = 2'd1;
    localparam req_id_t REQ_S = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester that follows `id` in the I -> D -> S -> I ring, `k` steps on.
    function automatic req_id_t rr_step(input req_id_t id, input int k);
        return req_id_t'((int'(id) + k) % NUM_REQ);
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational winner selection: STB override when prio is set, otherwise
// round-robin starting at the requester after last_grant.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            last_grant,
    input  logic               prio,
    output req_id_t            winner,
    output logic               valid
);

    req_id_t cand;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner = REQ_I;
        cand   = REQ_I;
        valid  = |req;
        if (prio && req[REQ_S]) begin
            winner = REQ_S;
        end else begin
            // Walk the ring from farthest to nearest so the nearest requester wins.
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = rr_step(last_grant, k);
                if (req[cand]) winner = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between iCache fill, dCache fill and STB drain.
// IDLE grants and latches a request, BUSY holds it until memAck, RESP acks.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_BITS = 32,
    parameter int LINE_BITS    = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iReq,
    input  logic [ADDRESS_BITS-1:0] iAddr,
    output logic                    iAck,
    input  logic                    dReq,
    input  logic [ADDRESS_BITS-1:0] dAddr,
    output logic                    dAck,
    input  logic                    wMemReq,
    input  logic [ADDRESS_BITS-1:0] wAddrMem,
    input  logic [LINE_BITS-1:0]    wDataMem,
    output logic                    wMemAck,
    input  logic                    stbFull,
    output logic [LINE_BITS-1:0]    rData,
    output logic                    memReq,
    output logic                    memWe,
    output logic [ADDRESS_BITS-1:0] memAddr,
    output logic [LINE_BITS-1:0]    memWData,
    input  logic                    memAck,
    input  logic [LINE_BITS-1:0]    memRData
);

    state_t                  state, next_state;
    req_id_t                 cur_id;
    req_id_t                 last_grant;
    req_id_t                 pick_winner;
    logic                    pick_valid;
    logic [ADDRESS_BITS-1:0] sel_addr;
    logic [LINE_BITS-1:0]    sel_wdata;

    mem_arb_rr_pick u_pick (
        .req        ({wMemReq, dReq, iReq}),
        .last_grant (last_grant),
        .prio       (stbFull),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        sel_addr  = iAddr;
        sel_wdata = '0;
        case (pick_winner)
            REQ_D: sel_addr = dAddr;
            REQ_S: begin
                sel_addr  = wAddrMem;
                sel_wdata = wDataMem;
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (pick_valid) next_state = ST_BUSY;
            ST_BUSY: if (memAck) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Reset abandons any in-flight transaction; a late memAck then lands in IDLE and is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_id     <= REQ_I;
            last_grant <= REQ_S;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWData   <= '0;
            iAck       <= 1'b0;
            dAck       <= 1'b0;
            wMemAck    <= 1'b0;
            rData      <= '0;
        end else begin
            iAck    <= 1'b0;
            dAck    <= 1'b0;
            wMemAck <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        cur_id     <= pick_winner;
                        last_grant <= pick_winner;
                        memReq     <= 1'b1;
                        memWe      <= (pick_winner == REQ_S);
                        memAddr    <= sel_addr;
                        memWData   <= sel_wdata;
                    end
                end
                ST_BUSY: begin
                    if (memAck) begin
                        memReq  <= 1'b0;
                        if (!memWe) rData <= memRData;
                        iAck    <= (cur_id == REQ_I);
                        dAck    <= (cur_id == REQ_D);
                        wMemAck <= (cur_id == REQ_S);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// stretch, all checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          iReq, dReq, wMemReq, stbFull;
    logic [AW-1:0] iAddr, dAddr, wAddrMem;
    logic [LW-1:0] wDataMem;
    logic          iAck, dAck, wMemAck;
    logic [LW-1:0] rData;
    logic          memReq, memWe;
    logic [AW-1:0] memAddr;
    logic [LW-1:0] memWData;
    logic          memAck;
    logic [LW-1:0] memRData;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int            last_g;
    logic [LW-1:0] exp_rdata;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata;
    logic          exp_we;

    mem_arbiter #(.ADDRESS_BITS(AW), .LINE_BITS(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .iReq     (iReq),
        .iAddr    (iAddr),
        .iAck     (iAck),
        .dReq     (dReq),
        .dAddr    (dAddr),
        .dAck     (dAck),
        .wMemReq  (wMemReq),
        .wAddrMem (wAddrMem),
        .wDataMem (wDataMem),
        .wMemAck  (wMemAck),
        .stbFull  (stbFull),
        .rData    (rData),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memAck   (memAck),
        .memRData (memRData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full-STB drain wins outright; otherwise the first requester met
    // walking the ring I -> D -> S after the last grant.
    function automatic int model_pick(input logic [2:0] r, input logic full, input int last);
        int order[3];
        if (full && r[2]) return 2;
        for (int k = 0; k < 3; k++) order[k] = (last + 1 + k) % 3;
        foreach (order[k]) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int id);
        logic [2:0] v;
        v = 3'b000;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic drop_req(input int id);
        case (id)
            0:       iReq    = 1'b0;
            1:       dReq    = 1'b0;
            default: wMemReq = 1'b0;
        endcase
    endtask

    // Called at a negedge while the DUT is in IDLE with requests applied.
    task automatic run_txn(input int waits, input bit drop_in_busy, input bit retire);
        int            w;
        logic [LW-1:0] rd;
        w = model_pick({wMemReq, dReq, iReq}, stbFull, last_g);
        if (w < 0) begin
            @(negedge clk);
            check("idle_no_req", LW'(memReq), LW'(0));
            return;
        end
        exp_we    = (w == 2);
        exp_addr  = (w == 0) ? iAddr : (w == 1) ? dAddr : wAddrMem;
        exp_wdata = (w == 2) ? wDataMem : '0;
        @(negedge clk);
        check("grant_memReq", LW'(memReq), LW'(1));
        check("grant_memWe", LW'(memWe), LW'(exp_we));
        check("grant_memAddr", LW'(memAddr), LW'(exp_addr));
        check("grant_memWData", memWData, exp_wdata);
        if (drop_in_busy) drop_req(w);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("busy_memReq", LW'(memReq), LW'(1));
            check("busy_memAddr", LW'(memAddr), LW'(exp_addr));
            check("busy_acks", LW'({wMemAck, dAck, iAck}), LW'(0));
        end
        rd       = rand_line();
        memAck   = 1'b1;
        memRData = rd;
        @(negedge clk);
        memAck   = 1'b0;
        memRData = rand_line();
        if (!exp_we) exp_rdata = rd;
        last_g = w;
        check("resp_memReq", LW'(memReq), LW'(0));
        check("resp_acks", LW'({wMemAck, dAck, iAck}), LW'(onehot(w)));
        check("resp_rData", rData, exp_rdata);
        if (retire) drop_req(w);
        @(negedge clk);
        check("ack_one_cycle", LW'({wMemAck, dAck, iAck}), LW'(0));
    endtask

    initial begin
        rst = 1'b1;
        {iReq, dReq, wMemReq, stbFull, memAck} = '0;
        iAddr = '0; dAddr = '0; wAddrMem = '0; wDataMem = '0; memRData = '0;
        last_g = 2; exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_we = 1'b0;

        #3;
        check("reset_memReq", LW'(memReq), LW'(0));
        check("reset_outs", LW'({memWe, iAck, dAck, wMemAck}), LW'(0));
        check("reset_memAddr", LW'(memAddr), LW'(0));
        check("reset_rData", rData, '0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all three held: I, D, S, I at 3-cycle spacing
        iReq = 1'b1; dReq = 1'b1; wMemReq = 1'b1;
        iAddr = 32'h1000; dAddr = 32'h2000; wAddrMem = 32'h3000; wDataMem = rand_line();
        for (int t = 0; t < 4; t++) run_txn(0, 1'b0, 1'b0);
        {iReq, dReq, wMemReq} = '0;

        // Single read with memAck two cycles after memReq
        @(negedge clk);
        iReq = 1'b1; iAddr = 32'h100;
        run_txn(2, 1'b0, 1'b1);

        // Stale request: dReq drops during its own BUSY
        dReq = 1'b1; dAddr = $urandom;
        run_txn(1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stale_no_regrant", LW'(memReq), LW'(0));
        end

        // Spurious memAck in IDLE
        memAck = 1'b1; memRData = rand_line();
        @(negedge clk);
        memAck = 1'b0;
        @(negedge clk);
        check("spur_memReq", LW'(memReq), LW'(0));
        check("spur_acks", LW'({wMemAck, dAck, iAck}), LW'(0));
        check("spur_rData", rData, exp_rdata);
        check("spur_memAddr", LW'({memWe, memAddr}), LW'({exp_we, exp_addr}));
        check("spur_memWData", memWData, exp_wdata);

        // Full-STB priority: make S the last grant, then all request with stbFull
        wMemReq = 1'b1; stbFull = 1'b1; wAddrMem = $urandom; wDataMem = rand_line();
        run_txn(0, 1'b0, 1'b1);
        iReq = 1'b1; dReq = 1'b1; wMemReq = 1'b1;
        wAddrMem = $urandom; wDataMem = rand_line();
        run_txn(1, 1'b0, 1'b1);
        {iReq, dReq, wMemReq, stbFull} = '0;

        // Randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            iReq     = 1'($urandom_range(0, 1));
            dReq     = 1'($urandom_range(0, 1));
            wMemReq  = 1'($urandom_range(0, 1));
            stbFull  = 1'($urandom_range(0, 1));
            iAddr    = $urandom;
            dAddr    = $urandom;
            wAddrMem = $urandom;
            wDataMem = rand_line();
            run_txn($urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
        end
        {iReq, dReq, wMemReq, stbFull} = '0;
        @(negedge clk);

        // Reset in the middle of an STB write, then a late memAck
        wMemReq = 1'b1; stbFull = 1'b1; wAddrMem = $urandom; wDataMem = rand_line();
        @(negedge clk);
        check("rst_pre_grant", LW'({memReq, memWe}), LW'(2'b11));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_outs", LW'({memReq, memWe, iAck, dAck, wMemAck}), LW'(0));
        check("rst_async_addr", LW'(memAddr), LW'(0));
        check("rst_async_wdata", memWData, '0);
        check("rst_async_rData", rData, '0);
        @(negedge clk);
        rst = 1'b0;
        last_g = 2; exp_rdata = '0;
        memAck = 1'b1; memRData = rand_line();
        iReq = 1'b1; iAddr = $urandom; stbFull = 1'b0;
        @(negedge clk);
        memAck = 1'b0;
        check("rst_late_ack_none", LW'(wMemAck), LW'(0));
        check("rst_first_grant_I", LW'({memReq, memWe}), LW'(2'b10));
        check("rst_first_addr", LW'(memAddr), LW'(iAddr));
        memAck = 1'b1; memRData = rand_line();
        exp_rdata = memRData;
        @(negedge clk);
        memAck = 1'b0;
        check("rst_then_acks", LW'({wMemAck, dAck, iAck}), LW'(3'b001));
        check("rst_then_rData", rData, exp_rdata);
        {iReq, wMemReq} = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
